// File: rtl/mem_arbiter_if.sv
// Bus bundle for the IF/MEM memory arbiter: both upstream request ports,
// the pipeline stall outputs and the downstream memory port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic              i_err_o;
  logic [DATA_W-1:0] i_rdata_o;

  logic                d_req_i;
  logic                d_we_i;
  logic [ADDR_W-1:0]   d_addr_i;
  logic [DATA_W-1:0]   d_wdata_i;
  logic [DATA_W/8-1:0] d_be_i;
  logic                d_ack_o;
  logic                d_err_o;
  logic [DATA_W-1:0]   d_rdata_o;

  logic stall_if_o;
  logic stall_mem_o;

  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic                mem_ack_i;
  logic [DATA_W-1:0]   mem_rdata_i;

  // The arbiter itself serves requests, so it takes the slave side.
  modport slave (
    input  i_req_i, i_addr_i,
    output i_ack_o, i_err_o, i_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output d_ack_o, d_err_o, d_rdata_o,
    output stall_if_o, stall_mem_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_ack_o, i_err_o, i_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  d_ack_o, d_err_o, d_rdata_o,
    input  stall_if_o, stall_mem_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch
// and the data port, with data priority, alternation and an access timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              d_grant, i_grant, timeout_hit, done, done_err;
  logic [DATA_W-1:0] done_data;

  // A port acked this cycle is still showing its finished request; masking it lets the other port in.
  assign d_grant     = bus.d_req_i & ~d_ack_q;
  assign i_grant     = bus.i_req_i & ~i_ack_q;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
  assign done        = bus.mem_ack_i | timeout_hit;
  assign done_err    = ~bus.mem_ack_i;
  assign done_data   = bus.mem_ack_i ? bus.mem_rdata_i : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_grant) begin
          state_d     = D_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we_i;
          mem_addr_d  = bus.d_addr_i;
          mem_wdata_d = bus.d_wdata_i;
          mem_be_d    = bus.d_be_i;
        end else if (i_grant) begin
          state_d    = I_ACC;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.i_addr_i;
          mem_be_d   = '1;
        end
      end
      I_ACC, D_ACC: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == D_ACC) begin
            d_ack_d   = 1'b1;
            d_err_d   = done_err;
            d_rdata_d = done_data;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = done_err;
            i_rdata_d = done_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.i_ack_o     = i_ack_q;
  assign bus.i_err_o     = i_err_q;
  assign bus.i_rdata_o   = i_rdata_q;
  assign bus.d_ack_o     = d_ack_q;
  assign bus.d_err_o     = d_err_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.stall_if_o  = bus.i_req_i & ~i_ack_q;
  assign bus.stall_mem_o = bus.d_req_i & ~d_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal latency/data expectations for each scenario.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks once mem_req_o has been high for ack_delay+1 cycles (never if negative).
  int          ack_delay = 1;
  bit          spur_ack  = 1'b0;
  bit          rd_fix_en = 1'b0;
  logic [31:0] rd_fix    = '0;
  int          hi_cnt    = 0;

  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_req_o === 1'b1) hi_cnt++;
      else hi_cnt = 0;
      bus.mem_ack_i   = spur_ack || (bus.mem_req_o === 1'b1 && ack_delay >= 0 && hi_cnt == ack_delay + 1);
      bus.mem_rdata_i = rd_fix_en ? rd_fix : (32'hC0DE0000 ^ bus.mem_addr_o);
    end
  end

  // Grant log: one entry per rising edge of mem_req_o.
  logic [31:0] grant_addr[$];
  bit          grant_we[$];
  bit          prev_req = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req_o === 1'b1 && !prev_req) begin
        grant_addr.push_back(bus.mem_addr_o);
        grant_we.push_back(bus.mem_we_o);
      end
      prev_req = (bus.mem_req_o === 1'b1);
    end
  end

  // Transaction model: one outstanding access, aborted TO cycles after it was granted.
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_is_d  = 1'b0;
  longint      m_cyc   = 0;
  longint      m_grant_cyc = 0;
  logic          e_mem_req, e_mem_we;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata;
  logic [BW-1:0] e_mem_be;
  logic          e_i_ack, e_i_err, e_d_ack, e_d_err;
  logic [DW-1:0] e_i_rdata, e_d_rdata;

  task automatic model_complete(input bit err, input logic [DW-1:0] val);
    e_mem_req = 1'b0;
    m_busy    = 1'b0;
    if (m_is_d) begin
      e_d_ack = 1'b1; e_d_err = err; e_d_rdata = val;
    end else begin
      e_i_ack = 1'b1; e_i_err = err; e_i_rdata = val;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      m_cyc++;
      if (rst_n !== 1'b1) begin
        m_valid = 1'b1; m_busy = 1'b0;
        e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_be = '0;
        e_i_ack = 0; e_i_err = 0; e_i_rdata = '0;
        e_d_ack = 0; e_d_err = 0; e_d_rdata = '0;
      end else begin
        bit d_ok, i_ok;
        d_ok = bus.d_req_i && !e_d_ack;
        i_ok = bus.i_req_i && !e_i_ack;
        e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;
        if (m_busy) begin
          if (bus.mem_ack_i) model_complete(1'b0, bus.mem_rdata_i);
          else if (TO > 0 && m_cyc == m_grant_cyc + TO) model_complete(1'b1, '0);
        end else if (d_ok || i_ok) begin
          m_busy = 1'b1; m_is_d = d_ok; m_grant_cyc = m_cyc; e_mem_req = 1'b1;
          if (d_ok) begin
            e_mem_we = bus.d_we_i; e_mem_addr = bus.d_addr_i;
            e_mem_wdata = bus.d_wdata_i; e_mem_be = bus.d_be_i;
          end else begin
            e_mem_we = 1'b0; e_mem_addr = bus.i_addr_i; e_mem_be = '1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check_output("mem_req", bus.mem_req_o, e_mem_req);
        check_output("mem_we", bus.mem_we_o, e_mem_we);
        check_output("mem_addr", bus.mem_addr_o, e_mem_addr);
        check_output("mem_wdata", bus.mem_wdata_o, e_mem_wdata);
        check_output("mem_be", bus.mem_be_o, e_mem_be);
        check_output("i_ack", bus.i_ack_o, e_i_ack);
        check_output("i_err", bus.i_err_o, e_i_err);
        check_output("i_rdata", bus.i_rdata_o, e_i_rdata);
        check_output("d_ack", bus.d_ack_o, e_d_ack);
        check_output("d_err", bus.d_err_o, e_d_err);
        check_output("d_rdata", bus.d_rdata_o, e_d_rdata);
        check_output("stall_if", bus.stall_if_o, bus.i_req_i & ~e_i_ack);
        check_output("stall_mem", bus.stall_mem_o, bus.d_req_i & ~e_d_ack);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts negedges from the current cycle until the port acks; returns at the ack negedge.
  task automatic wait_ack(input bit want_d, input string tag, output int lat, output int stalls);
    lat = 0;
    stalls = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (want_d ? bus.d_ack_o : bus.i_ack_o) break;
      if (want_d ? bus.stall_mem_o : bus.stall_if_o) stalls++;
      lat++;
    end
    if (lat >= 40) check_output({tag, "_ack_seen"}, 64'd0, 64'd1);
  endtask

  task automatic apply_stimulus_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_addr_i = addr; bus.d_wdata_i = wdata; bus.d_be_i = be;
  endtask

  task automatic apply_stimulus_i(input logic [31:0] addr);
    bus.i_req_i = 1'b1; bus.i_addr_i = addr;
  endtask

  initial begin
    int lat, st, acks;
    bus.i_req_i = 0; bus.i_addr_i = '0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_be_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_mem_req", bus.mem_req_o, 0);
    check_output("rst_mem_addr", bus.mem_addr_o, 0);
    check_output("rst_d_rdata", bus.d_rdata_o, 0);
    check_output("rst_i_ack", bus.i_ack_o, 0);
    step(1); rst_n = 1'b1;
    step(2);

    // Fetch only, memory acks one cycle after mem_req_o.
    ack_delay = 1; rd_fix_en = 1; rd_fix = 32'h00500093;
    grant_addr.delete(); grant_we.delete();
    apply_stimulus_i(32'h100);
    wait_ack(1'b0, "t1", lat, st);
    check_output("t1_lat", lat, 3);
    check_output("t1_stall_cycles", st, 3);
    check_output("t1_rdata", bus.i_rdata_o, 32'h00500093);
    check_output("t1_err", bus.i_err_o, 0);
    step(1); bus.i_req_i = 0;
    check_output("t1_grants", grant_addr.size(), 1);
    check_output("t1_addr", grant_addr[0], 32'h100);
    check_output("t1_we", grant_we[0], 0);
    step(2);

    // Simultaneous store and fetch: store first, fetch granted in the store's ack cycle.
    rd_fix_en = 0;
    grant_addr.delete(); grant_we.delete();
    apply_stimulus_d(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF);
    apply_stimulus_i(32'h104);
    wait_ack(1'b1, "t2d", lat, st);
    check_output("t2_d_lat", lat, 3);
    step(1); bus.d_req_i = 0; bus.d_we_i = 0;
    wait_ack(1'b0, "t2i", lat, st);
    check_output("t2_i_lat", lat, 2);
    check_output("t2_i_rdata", bus.i_rdata_o, 32'hC0DE0104);
    step(1); bus.i_req_i = 0;
    step(3);
    check_output("t2_grants", grant_addr.size(), 2);
    check_output("t2_g0_addr", grant_addr[0], 32'h2000);
    check_output("t2_g0_we", grant_we[0], 1);
    check_output("t2_g1_addr", grant_addr[1], 32'h104);
    check_output("t2_g1_we", grant_we[1], 0);

    // Continuous contention alternates D, I, D, I.
    grant_addr.delete(); grant_we.delete();
    apply_stimulus_d(1'b0, 32'h3000, 32'h0, 4'hF);
    apply_stimulus_i(32'h200);
    acks = 0;
    for (int k = 0; k < 60 && acks < 4; k++) begin
      @(negedge clk);
      acks += int'(bus.d_ack_o) + int'(bus.i_ack_o);
    end
    check_output("t3_acks", acks, 4);
    step(1); bus.d_req_i = 0; bus.i_req_i = 0;
    step(6);
    check_output("t3_grants", grant_addr.size(), 5);
    check_output("t3_g0", grant_addr[0], 32'h3000);
    check_output("t3_g1", grant_addr[1], 32'h200);
    check_output("t3_g2", grant_addr[2], 32'h3000);
    check_output("t3_g3", grant_addr[3], 32'h200);

    // Memory never acks: abort with error after TO cycles of mem_req_o.
    ack_delay = -1;
    apply_stimulus_d(1'b0, 32'h40, 32'h0, 4'hF);
    wait_ack(1'b1, "t4", lat, st);
    check_output("t4_lat", lat, TO + 1);
    check_output("t4_err", bus.d_err_o, 1);
    check_output("t4_rdata", bus.d_rdata_o, 0);
    check_output("t4_mem_req", bus.mem_req_o, 0);
    step(1); bus.d_req_i = 0; ack_delay = 1;
    step(1);
    apply_stimulus_i(32'h108);
    wait_ack(1'b0, "t4i", lat, st);
    check_output("t4_i_lat", lat, 3);
    check_output("t4_i_err", bus.i_err_o, 0);
    check_output("t4_i_rdata", bus.i_rdata_o, 32'hC0DE0108);
    step(1); bus.i_req_i = 0;
    step(1);

    // Ack lands on the last timeout cycle: normal completion.
    ack_delay = TO - 1; rd_fix_en = 1; rd_fix = 32'h1234;
    apply_stimulus_d(1'b0, 32'h44, 32'h0, 4'hF);
    wait_ack(1'b1, "t5", lat, st);
    check_output("t5_lat", lat, TO + 1);
    check_output("t5_err", bus.d_err_o, 0);
    check_output("t5_rdata", bus.d_rdata_o, 32'h1234);
    step(1); bus.d_req_i = 0; rd_fix_en = 0;
    step(1);

    // Minimum latency: memory acks in the first mem_req_o cycle.
    ack_delay = 0;
    apply_stimulus_d(1'b1, 32'h50, 32'h55AA, 4'b0011);
    wait_ack(1'b1, "t5b", lat, st);
    check_output("t5b_lat", lat, 2);
    check_output("t5b_be", bus.mem_be_o, 4'b0011);
    step(1); bus.d_req_i = 0; bus.d_we_i = 0;
    step(1);

    // Reset in the middle of a data access, then a stray mem_ack_i.
    ack_delay = -1;
    apply_stimulus_d(1'b0, 32'h48, 32'h0, 4'hF);
    step(3);
    rst_n = 1'b0; bus.d_req_i = 0;
    step(1);
    rst_n = 1'b1; spur_ack = 1;
    @(negedge clk);
    check_output("t6_mem_req", bus.mem_req_o, 0);
    check_output("t6_mem_addr", bus.mem_addr_o, 0);
    check_output("t6_d_ack", bus.d_ack_o, 0);
    check_output("t6_d_rdata", bus.d_rdata_o, 0);
    check_output("t6_i_rdata", bus.i_rdata_o, 0);
    step(1); spur_ack = 0; ack_delay = 1;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      acks += int'(bus.d_ack_o) + int'(bus.mem_req_o);
    end
    check_output("t6_quiet", acks, 0);
    step(1);
    apply_stimulus_i(32'h10C);
    wait_ack(1'b0, "t6i", lat, st);
    check_output("t6_i_lat", lat, 3);
    check_output("t6_i_rdata", bus.i_rdata_o, 32'hC0DE010C);
    step(1); bus.i_req_i = 0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
